tart_sig_framer: RTL and testbench

- Sits directly upstream of tart_correlator, in the sig_clock domain.
- Takes the raw, per-antenna 1-bit I/Q sample stream from the radio capture front-end and slices it into correlator blocks of COUNT = LOOP0*LOOP1 samples.
- Drives sig_valid/sig_first/sig_last/sig_idata/sig_qdata on those block boundaries.
- Handles start/stop requests and frame-count limits so a block is never truncated.

---
 rtl/tart_sig_framer.sv | 187 ++++++++++++++++++
 tb/tb_tart_sig_framer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_sig_framer.sv
// Slices the raw per-antenna 1-bit I/Q stream into correlator blocks of LOOP0*LOOP1 samples.
// Optional test-pattern LFSR source enabled by TART_SIG_PATTERN_EN.
module tart_sig_framer #(
  parameter int WIDTH = 16,
  parameter int LOOP0 = 3,
  parameter int LOOP1 = 5,
  parameter int CBITS = 4,
  parameter int FBITS = 16
) (
  input  logic             sig_clock,
  input  logic             reset_n,
  input  logic             ant_valid_i,
  input  logic [WIDTH-1:0] ant_idata_i,
  input  logic [WIDTH-1:0] ant_qdata_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [FBITS-1:0] frames_i,
  input  logic             pattern_i,
  output logic             sig_valid_o,
  output logic             sig_first_o,
  output logic             sig_last_o,
  output logic [WIDTH-1:0] sig_idata_o,
  output logic [WIDTH-1:0] sig_qdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [FBITS-1:0] frame_count_o
);

  localparam int               COUNT    = LOOP0 * LOOP1;
  localparam logic [CBITS-1:0] LAST_IDX = CBITS'(COUNT - 1);
  localparam logic [CBITS-1:0] C_ONE    = CBITS'(1);
  localparam logic [FBITS-1:0] F_ONE    = FBITS'(1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [FBITS-1:0] limit_q, limit_d;
  logic [FBITS-1:0] fcnt_q, fcnt_d;
  logic [FBITS-1:0] fcnt_inc;
  logic             stop_q, stop_d;
  logic             vld_q, vld_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] idata_q, idata_d;
  logic [WIDTH-1:0] qdata_q, qdata_d;
  logic             accept;
  logic             is_last;

`ifdef TART_SIG_PATTERN_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [2*WIDTH-1:0] pat_dat;
  assign pat_dat = (2*WIDTH)'(lfsr_q);
`else
  logic unused_pattern;
  assign unused_pattern = pattern_i;
`endif

  assign fcnt_inc = fcnt_q + F_ONE;
  assign is_last  = (cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    fcnt_d  = fcnt_q;
    stop_d  = stop_q;
    vld_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    idata_d = idata_q;
    qdata_d = qdata_q;
    done_d  = (state_q == DRAIN);
    accept  = 1'b0;
`ifdef TART_SIG_PATTERN_EN
    lfsr_d  = lfsr_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          limit_d = frames_i;
          fcnt_d  = '0;
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = ARM;
`ifdef TART_SIG_PATTERN_EN
          lfsr_d  = LFSR_SEED;
`endif
        end
      end
      ARM: begin
        if (ant_valid_i) begin
          accept  = 1'b1;
          state_d = RUN;
          if (stop_i) stop_d = 1'b1;
        end else if (stop_i) begin
          state_d = DRAIN;
        end
      end
      RUN: begin
        if (stop_i) stop_d = 1'b1;
        accept = ant_valid_i;
      end
      DRAIN: begin
        stop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A block only ever ends on its last sample, so stop requests wait for it.
    if (accept) begin
      vld_d   = 1'b1;
      first_d = (cnt_q == '0);
      last_d  = is_last;
      idata_d = ant_idata_i;
      qdata_d = ant_qdata_i;
`ifdef TART_SIG_PATTERN_EN
      if (pattern_i) begin
        {idata_d, qdata_d} = pat_dat;
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
      end
`endif
      if (is_last) begin
        cnt_d  = '0;
        fcnt_d = fcnt_inc;
        if (stop_q || stop_i || ((limit_q != '0) && (fcnt_inc == limit_q)))
          state_d = DRAIN;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sig_clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      fcnt_q  <= '0;
      stop_q  <= 1'b0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idata_q <= '0;
      qdata_q <= '0;
`ifdef TART_SIG_PATTERN_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      fcnt_q  <= fcnt_d;
      stop_q  <= stop_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idata_q <= idata_d;
      qdata_q <= qdata_d;
`ifdef TART_SIG_PATTERN_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign sig_valid_o   = vld_q;
  assign sig_first_o   = first_q;
  assign sig_last_o    = last_q;
  assign sig_idata_o   = idata_q;
  assign sig_qdata_o   = qdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign frame_count_o = fcnt_q;

endmodule

// File: tb/tb_tart_sig_framer.sv
// Directed bench for tart_sig_framer: block slicing, stop/limit handling, gaps, reset, pattern.
module tb_tart_sig_framer;

  localparam int WIDTH = 16;
  localparam int FBITS = 16;

  logic             sig_clock = 1'b0;
  logic             reset_n;
  logic             ant_valid_i;
  logic [WIDTH-1:0] ant_idata_i;
  logic [WIDTH-1:0] ant_qdata_i;
  logic             start_i;
  logic             stop_i;
  logic [FBITS-1:0] frames_i;
  logic             pattern_i;
  logic             sig_valid_o;
  logic             sig_first_o;
  logic             sig_last_o;
  logic [WIDTH-1:0] sig_idata_o;
  logic [WIDTH-1:0] sig_qdata_o;
  logic             busy_o;
  logic             done_o;
  logic [FBITS-1:0] frame_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sig_clock = ~sig_clock;

  tart_sig_framer dut (
    .sig_clock     (sig_clock),
    .reset_n       (reset_n),
    .ant_valid_i   (ant_valid_i),
    .ant_idata_i   (ant_idata_i),
    .ant_qdata_i   (ant_qdata_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .frames_i      (frames_i),
    .pattern_i     (pattern_i),
    .sig_valid_o   (sig_valid_o),
    .sig_first_o   (sig_first_o),
    .sig_last_o    (sig_last_o),
    .sig_idata_o   (sig_idata_o),
    .sig_qdata_o   (sig_qdata_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .frame_count_o (frame_count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sig_clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] idat(input int n);
    return WIDTH'(n * 37 + 5);
  endfunction

  function automatic logic [WIDTH-1:0] qdat(input int n);
    return ~WIDTH'(n * 91 + 3);
  endfunction

  task automatic drive_sample(input int n);
    ant_valid_i = 1'b1;
    ant_idata_i = idat(n);
    ant_qdata_i = qdat(n);
  endtask

  task automatic do_start(input logic [FBITS-1:0] frames);
    frames_i = frames;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(sig_valid_o), 64'd0);
    chk({tag, "_first"}, 64'(sig_first_o), 64'd0);
    chk({tag, "_last"},  64'(sig_last_o),  64'd0);
    chk({tag, "_idata"}, 64'(sig_idata_o), 64'd0);
    chk({tag, "_qdata"}, 64'(sig_qdata_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o),      64'd0);
    chk({tag, "_done"},  64'(done_o),      64'd0);
    chk({tag, "_fcnt"},  64'(frame_count_o), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] last_i;
    int               s;
    int               pulses;
    bit               seen;

    reset_n     = 1'b0;
    ant_valid_i = 1'b0;
    ant_idata_i = '0;
    ant_qdata_i = '0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    frames_i    = '0;
    pattern_i   = 1'b0;

    // Reset state
    tick();
    tick();
    check_all_zero("rst");
    reset_n = 1'b1;

    // One block, limit 1
    do_start(16'd1);
    chk("t1_busy_arm", 64'(busy_o), 64'd1);
    chk("t1_valid_arm", 64'(sig_valid_o), 64'd0);
    for (int n = 0; n < 15; n++) begin
      drive_sample(n);
      tick();
      chk($sformatf("t1_valid_%0d", n), 64'(sig_valid_o), 64'd1);
      chk($sformatf("t1_first_%0d", n), 64'(sig_first_o), 64'(n == 0));
      chk($sformatf("t1_last_%0d", n),  64'(sig_last_o),  64'(n == 14));
      chk($sformatf("t1_idata_%0d", n), 64'(sig_idata_o), 64'(idat(n)));
      chk($sformatf("t1_qdata_%0d", n), 64'(sig_qdata_o), 64'(qdat(n)));
      chk($sformatf("t1_done_%0d", n),  64'(done_o), 64'd0);
    end
    ant_valid_i = 1'b0;
    tick();
    chk("t1_valid_end", 64'(sig_valid_o), 64'd0);
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_busy_end", 64'(busy_o), 64'd0);
    chk("t1_fcnt", 64'(frame_count_o), 64'd1);
    tick();
    chk("t1_done_pulse", 64'(done_o), 64'd0);

    // Continuous, stop at sample 20
    do_start(16'd0);
    chk("t2_fcnt_clr", 64'(frame_count_o), 64'd0);
    for (int n = 0; n < 40; n++) begin
      drive_sample(n);
      stop_i = (n == 20);
      tick();
      chk($sformatf("t2_valid_%0d", n), 64'(sig_valid_o), 64'(n < 30));
      chk($sformatf("t2_first_%0d", n), 64'(sig_first_o), 64'(n == 0 || n == 15));
      chk($sformatf("t2_last_%0d", n),  64'(sig_last_o),  64'(n == 14 || n == 29));
      chk($sformatf("t2_done_%0d", n),  64'(done_o), 64'(n == 30));
      chk($sformatf("t2_busy_%0d", n),  64'(busy_o), 64'(n < 30));
    end
    stop_i = 1'b0;
    ant_valid_i = 1'b0;
    chk("t2_fcnt", 64'(frame_count_o), 64'd2);
    chk("t2_hold_idata", 64'(sig_idata_o), 64'(idat(29)));

    // Gap every third cycle, limit 2
    do_start(16'd2);
    s = 0;
    pulses = 0;
    last_i = '0;
    for (int k = 0; k < 45; k++) begin
      if (k % 3 != 2) drive_sample(s);
      else ant_valid_i = 1'b0;
      tick();
      if (ant_valid_i) begin
        chk($sformatf("t3_valid_%0d", k), 64'(sig_valid_o), 64'd1);
        chk($sformatf("t3_first_%0d", k), 64'(sig_first_o), 64'(s == 0 || s == 15));
        chk($sformatf("t3_last_%0d", k),  64'(sig_last_o),  64'(s == 14 || s == 29));
        chk($sformatf("t3_idata_%0d", k), 64'(sig_idata_o), 64'(idat(s)));
        last_i = idat(s);
        s++;
      end else begin
        chk($sformatf("t3_gap_valid_%0d", k), 64'(sig_valid_o), 64'd0);
        chk($sformatf("t3_gap_fl_%0d", k), 64'({sig_first_o, sig_last_o}), 64'd0);
        chk($sformatf("t3_gap_hold_%0d", k), 64'(sig_idata_o), 64'(last_i));
      end
      if (sig_valid_o) pulses++;
    end
    ant_valid_i = 1'b0;
    chk("t3_pulses", 64'(pulses), 64'd30);
    chk("t3_done", 64'(done_o), 64'd1);
    chk("t3_fcnt", 64'(frame_count_o), 64'd2);
    tick();

    // start and stop together in IDLE
    start_i = 1'b1;
    stop_i  = 1'b1;
    frames_i = 16'd0;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("t4_busy_ss", 64'(busy_o), 64'd0);
    drive_sample(0);
    tick();
    chk("t4_valid_ss", 64'(sig_valid_o), 64'd0);
    chk("t4_busy_ss2", 64'(busy_o), 64'd0);
    chk("t4_fcnt_ss", 64'(frame_count_o), 64'd2);
    ant_valid_i = 1'b0;

    // start while busy leaves the frame count alone
    do_start(16'd0);
    chk("t4_fcnt_clr", 64'(frame_count_o), 64'd0);
    for (int n = 0; n < 15; n++) begin
      drive_sample(n);
      tick();
    end
    chk("t4_fcnt_1", 64'(frame_count_o), 64'd1);
    drive_sample(15);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t4_fcnt_busy_start", 64'(frame_count_o), 64'd1);
    chk("t4_first_busy_start", 64'(sig_first_o), 64'd1);
    drive_sample(16);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    seen = 1'b0;
    for (int n = 17; n < 60 && !seen; n++) begin
      drive_sample(n);
      tick();
      if (sig_last_o) begin
        seen = 1'b1;
        chk("t4_last_at_29", 64'(n), 64'd29);
      end
    end
    chk("t4_last_seen", 64'(seen), 64'd1);
    ant_valid_i = 1'b0;
    tick();
    chk("t4_done", 64'(done_o), 64'd1);
    chk("t4_fcnt_2", 64'(frame_count_o), 64'd2);

    // Reset in mid-block
    do_start(16'd0);
    for (int n = 0; n < 7; n++) begin
      drive_sample(n);
      tick();
    end
    drive_sample(7);
    reset_n = 1'b0;
    tick();
    check_all_zero("t5_rst");
    reset_n = 1'b1;
    ant_valid_i = 1'b0;
    tick();
    chk("t5_idle_valid", 64'(sig_valid_o), 64'd0);
    do_start(16'd0);
    drive_sample(100);
    tick();
    chk("t5_valid", 64'(sig_valid_o), 64'd1);
    chk("t5_first", 64'(sig_first_o), 64'd1);
    chk("t5_idata", 64'(sig_idata_o), 64'(idat(100)));
    ant_valid_i = 1'b0;

`ifdef TART_SIG_PATTERN_EN
    begin
      logic [31:0] ref_lfsr;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      ref_lfsr = 32'hACE1_ACE1;
      do_start(16'd1);
      pattern_i = 1'b1;
      for (int n = 0; n < 15; n++) begin
        drive_sample(n);
        tick();
        chk($sformatf("t6_pat_%0d", n), 64'({sig_idata_o, sig_qdata_o}), 64'(ref_lfsr));
        ref_lfsr = {1'b0, ref_lfsr[31:1]} ^ (ref_lfsr[0] ? 32'h8020_0003 : 32'h0);
      end
      ant_valid_i = 1'b0;
      pattern_i = 1'b0;
      tick();
      chk("t6_done", 64'(done_o), 64'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
